// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator with a 2-entry (output + skid) elastic buffer.
// Decodes the immediate, its format, a PC-relative target and an illegal flag per instruction.
module imm_gen_pipe #(
  parameter int XLEN   = 32,
  parameter bit CSR_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_Z    = 3'd6;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [XLEN-1:0] target;
    logic            illegal;
  } entry_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] sext;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] imm_sh;
  logic            sh_illegal;
  logic            pc_rel;
  entry_t          dec;

  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  logic   out_valid_q, out_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q, in_ready_d;
  logic   accept;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];

  always_comb begin
    sext  = {XLEN{in_inst[31]}};
    imm_i = sext;
    imm_i[11:0] = in_inst[31:20];
    imm_s = sext;
    imm_s[11:0] = {in_inst[31:25], in_inst[11:7]};
    imm_b = sext;
    imm_b[12:0] = {in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    imm_u = sext;
    imm_u[31:0] = {in_inst[31:12], 12'b0};
    imm_j = sext;
    imm_j[20:0] = {in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
    imm_sh = '0;
    // RV64 shamt borrows bit 25 from funct7, leaving a 6-bit funct6 above it
    if (XLEN == 64) begin
      imm_sh[5:0] = in_inst[25:20];
      sh_illegal  = (funct3 == 3'b001 && in_inst[31:26] != 6'b0) ||
                    (funct3 == 3'b101 && in_inst[31:26] != 6'b0 && in_inst[31:26] != 6'b010000);
    end else begin
      imm_sh[4:0] = in_inst[24:20];
      sh_illegal  = in_inst[25] ||
                    (funct3 == 3'b001 && in_inst[31:25] != 7'b0) ||
                    (funct3 == 3'b101 && in_inst[31:25] != 7'b0 && in_inst[31:25] != 7'b0100000);
    end
  end

  always_comb begin
    dec.imm     = '0;
    dec.fmt     = FMT_NONE;
    dec.illegal = 1'b0;
    pc_rel      = 1'b0;
    if (in_inst[1:0] != 2'b11) begin
      dec.illegal = 1'b1;
    end else begin
      case (opcode)
        OP_LUI:    begin dec.fmt = FMT_U; dec.imm = imm_u; end
        OP_AUIPC:  begin dec.fmt = FMT_U; dec.imm = imm_u; pc_rel = 1'b1; end
        OP_JAL:    begin dec.fmt = FMT_J; dec.imm = imm_j; pc_rel = 1'b1; end
        OP_JALR,
        OP_LOAD:   begin dec.fmt = FMT_I; dec.imm = imm_i; end
        OP_IMM: begin
          dec.fmt = FMT_I;
          if (funct3 == 3'b001 || funct3 == 3'b101) begin
            dec.imm     = imm_sh;
            dec.illegal = sh_illegal;
          end else begin
            dec.imm = imm_i;
          end
        end
        OP_BRANCH: begin dec.fmt = FMT_B; dec.imm = imm_b; pc_rel = 1'b1; end
        OP_STORE:  begin dec.fmt = FMT_S; dec.imm = imm_s; end
        OP_OP:     begin dec.fmt = FMT_NONE; end
        OP_SYSTEM: begin
          if (CSR_EN) begin
            if (funct3 == 3'b100) begin
              dec.illegal = 1'b1;
            end else if (funct3[2]) begin
              dec.fmt      = FMT_Z;
              dec.imm[4:0] = in_inst[19:15];
            end else if (funct3 != 3'b000) begin
              dec.fmt       = FMT_I;
              dec.imm[11:0] = in_inst[31:20];
            end
          end
        end
        default:   dec.illegal = 1'b1;
      endcase
    end
    dec.target = pc_rel ? in_pc + dec.imm : '0;
  end

  assign accept = in_valid && in_ready_q;

  // The skid entry only fills while the output is stalled, so in_ready mirrors its emptiness.
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) out_d = dec;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_imm     = out_q.imm;
  assign out_fmt     = out_q.fmt;
  assign out_target  = out_q.target;
  assign out_illegal = out_q.illegal;

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter: XLEN, 32, datapath width (legal values 32 or 64).
REQ-002 SHALL have parameter: CSR_EN, 1, decode SYSTEM/CSR immediates when 1; otherwise treat opcode 1110011 as no-immediate.
REQ-003 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port: flush  in  1  synchronous pipeline kill.
REQ-006 SHALL have port: in_valid  in  1  upstream instruction valid.
REQ-007 SHALL have port: in_ready  out  1  block can accept; registered output.
REQ-008 SHALL have port: in_inst  in  32  raw instruction.
REQ-009 SHALL have port: in_pc  in  XLEN  instruction address.
REQ-010 SHALL have port: out_valid  out  1  result valid.
REQ-011 SHALL have port: out_ready  in  1  downstream accepts.
REQ-012 SHALL have port: out_imm  out  XLEN  decoded immediate.
REQ-013 SHALL have port: out_fmt  out  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm), 7 unused.
REQ-014 SHALL have port: out_target  out  XLEN  PC-relative target.
REQ-015 SHALL have port: out_illegal  out  1  malformed or unknown encoding.

Function
REQ-016 SHALL decode by opcode in_inst[6:0]: LUI/AUIPC -> U; JAL -> J; JALR/LOAD/ARI_ITYPE -> I; BRANCH -> B; STORE -> S; ARI_RTYPE -> NONE, imm 0.
REQ-017 SHALL sign-extend every I/S/B/U/J immediate from inst[31] to XLEN; U = inst[31:12]<<12; B and J bit 0 = 0.
REQ-018 SHALL, for ARI_ITYPE funct3 001/101, output zero-extended shamt: inst[24:20] when XLEN=32, inst[25:20] when XLEN=64.
REQ-019 SHALL set out_illegal for shifts when: XLEN=32 and inst[25]=1; funct3=001 with nonzero upper funct bits; funct3=101 with upper funct bits other than 0 or 0100000 (bit 30 only).
REQ-020 SHALL, when CSR_EN=1 and opcode 1110011: funct3[2]=1 -> Z, imm = zero-extended inst[19:15]; funct3 001/010/011 -> I, imm = zero-extended inst[31:20]; funct3 000 -> NONE, imm 0; funct3 100 -> illegal.
REQ-021 SHALL treat any other opcode, or inst[1:0] != 11, as NONE, imm 0, out_illegal=1.
REQ-022 SHALL compute out_target = in_pc + imm, modulo 2^XLEN, for AUIPC/JAL/BRANCH; 0 for all others.
REQ-023 SHALL register results: latency exactly 1 cycle from accepted input (in_valid & in_ready) to out_valid when downstream not stalled.
REQ-024 SHALL buffer 2 entries (output register plus skid register), preserving strict order.
REQ-025 SHALL drive in_ready = 0 exactly when the skid entry is occupied.
REQ-026 SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-027 SHALL, on a cycle with both a transfer out and an accept in, move the skid entry (if any) to the output and capture the new input without loss.
REQ-028 SHALL, on flush, invalidate both entries and drop any input offered that cycle; next cycle out_valid=0, in_ready=1.
REQ-029 SHALL never present out_valid with X data; invalid-cycle data contents are don't-care.

Reset
REQ-030 SHALL, on rst, set out_valid=0, in_ready=1, out_imm=0, out_fmt=0, out_target=0, out_illegal=0, and clear the skid entry.
REQ-031 SHALL give rst priority over flush and input; reset mid-stream discards all buffered instructions.

Verification
REQ-032 SHALL verify: in_inst=0x008000EF (JAL), in_pc=0x100, out_ready=1 -> next cycle out_valid=1, imm=0x8, fmt=5, target=0x108.
REQ-033 SHALL verify: in_inst=0xFE000EE3 (BEQ -4), in_pc=0x200 -> imm=0xFFFFFFFC (XLEN=32), fmt=3, target=0x1FC.
REQ-034 SHALL verify: out_ready=0, three back-to-back valid instructions A,B,C -> A,B accepted, in_ready=0 after B, C held; out_ready=1 -> A,B,C delivered in order, one per cycle.
REQ-035 SHALL verify: XLEN=32, in_inst=0x02001013 -> out_illegal=1, fmt=1; in_inst=0x3002D073 -> fmt=6, imm=5, out_illegal=0.
REQ-036 SHALL verify: both entries full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed input never appears.
REQ-037 SHALL verify: rst asserted with both entries full and flush=1 -> next cycle all outputs at REQ-030 values.
